// File: rtl/axis_shutdown_sequencer.sv
// Shutdown sequencer for a chain of AXI-Stream gates: closes gates 0..N-1 in order,
// reopens them N-1..0, and bounds every acknowledge wait with an optional timeout.
module axis_shutdown_sequencer #(
    parameter int C_NUM_CHANNELS   = 4,
    parameter int C_TIMEOUT_CYCLES = 1024,
    parameter int C_IDX_WIDTH      = (C_NUM_CHANNELS > 1) ? $clog2(C_NUM_CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stop_req,
    output logic [C_NUM_CHANNELS-1:0] shutdown_req,
    input  logic [C_NUM_CHANNELS-1:0] shutdown_ack,
    output logic                      running,
    output logic                      stopped,
    output logic                      busy,
    output logic                      timeout_flag,
    output logic [C_IDX_WIDTH-1:0]    timeout_channel,
    input  logic                      timeout_clr
);

    localparam int CNT_WIDTH = (C_TIMEOUT_CYCLES > 0) ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
    localparam logic TIMEOUT_EN = (C_TIMEOUT_CYCLES > 0);
    localparam logic [C_IDX_WIDTH-1:0] LAST_IDX = C_IDX_WIDTH'(C_NUM_CHANNELS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FIRE =
        CNT_WIDTH'((C_TIMEOUT_CYCLES > 0) ? (C_TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_RUNNING,
        S_STOPPING,
        S_STOPPED,
        S_STARTING
    } state_e;

    state_e                      state_q, state_d;
    logic [C_IDX_WIDTH-1:0]      idx_q, idx_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [C_NUM_CHANNELS-1:0]   req_q, req_d;
    logic                        running_q, running_d;
    logic                        stopped_q, stopped_d;
    logic                        busy_q, busy_d;
    logic                        flag_q, flag_d;
    logic [C_IDX_WIDTH-1:0]      chan_q, chan_d;

    logic                        ackSel;
    logic                        ackMatch;
    logic                        waiting;
    logic                        fire;
    logic                        advance;
    logic [C_IDX_WIDTH-1:0]      idxInc;
    logic [C_IDX_WIDTH-1:0]      idxDec;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        flag_d    = flag_q;
        chan_d    = chan_q;
        idxInc    = idx_q + 1'b1;
        idxDec    = idx_q - 1'b1;
        ackSel    = shutdown_ack[idx_q];
        waiting   = (state_q == S_STOPPING) || (state_q == S_STARTING);
        ackMatch  = (state_q == S_STOPPING) ? ackSel : ~ackSel;
        // A matched ack on the firing cycle takes priority over the timeout.
        fire      = waiting && !ackMatch && TIMEOUT_EN && (cnt_q == CNT_FIRE);
        advance   = waiting && (ackMatch || fire);

        case (state_q)
            S_RUNNING: begin
                if (stop_req) begin
                    state_d  = S_STOPPING;
                    idx_d    = '0;
                    cnt_d    = '0;
                    req_d[0] = 1'b1;
                end
            end
            S_STOPPING: begin
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_STOPPED;
                    end else begin
                        idx_d         = idxInc;
                        req_d[idxInc] = 1'b1;
                        cnt_d         = '0;
                    end
                end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOPPED: begin
                if (!stop_req) begin
                    state_d         = S_STARTING;
                    idx_d           = LAST_IDX;
                    cnt_d           = '0;
                    req_d[LAST_IDX] = 1'b0;
                end
            end
            S_STARTING: begin
                if (advance) begin
                    if (idx_q == '0) begin
                        state_d = S_RUNNING;
                    end else begin
                        idx_d         = idxDec;
                        req_d[idxDec] = 1'b0;
                        cnt_d         = '0;
                    end
                end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_RUNNING;
            end
        endcase

        // A new timeout beats a simultaneous clear; otherwise only the first one is recorded.
        if (fire && (!flag_q || timeout_clr)) begin
            flag_d = 1'b1;
            chan_d = idx_q;
        end else if (timeout_clr) begin
            flag_d = 1'b0;
            chan_d = '0;
        end

        running_d = (state_d == S_RUNNING);
        stopped_d = (state_d == S_STOPPED);
        busy_d    = (state_d == S_STOPPING) || (state_d == S_STARTING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUNNING;
            idx_q     <= '0;
            cnt_q     <= '0;
            req_q     <= '0;
            running_q <= 1'b1;
            stopped_q <= 1'b0;
            busy_q    <= 1'b0;
            flag_q    <= 1'b0;
            chan_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            running_q <= running_d;
            stopped_q <= stopped_d;
            busy_q    <= busy_d;
            flag_q    <= flag_d;
            chan_q    <= chan_d;
        end
    end

    assign shutdown_req    = req_q;
    assign running         = running_q;
    assign stopped         = stopped_q;
    assign busy            = busy_q;
    assign timeout_flag    = flag_q;
    assign timeout_channel = chan_q;

endmodule

// File: doc/axis_shutdown_sequencer.md
# axis_shutdown_sequencer

Sequences a chain of AXI-Stream shutdown gates so that a datapath is brought down in a fixed order (channel 0 first, typically the most upstream gate) and brought back up in reverse order. It drives the level `shutdown_req` of each gate, waits for each gate's `shutdown_ack` to confirm before touching the next, and bounds every wait with a timeout so that one stuck gate cannot hang the sequence. It sits between the control/register logic and the per-stream shutdown gates.

## Interface

- `C_NUM_CHANNELS`, 4: number of gates sequenced, 1..16.
- `C_TIMEOUT_CYCLES`, 1024: maximum wait per channel in cycles; 0 disables the timeout.
- `C_IDX_WIDTH`, derived as max(1, $clog2(C_NUM_CHANNELS)): width of channel indices.

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `stop_req` in 1: level input; 1 requests all gates shut, 0 requests all gates open.
- `shutdown_req` out C_NUM_CHANNELS: one bit per gate; registered.
- `shutdown_ack` in C_NUM_CHANNELS: per-gate acknowledge, level.
- `running` out 1: all gates open and the sequence is idle.
- `stopped` out 1: all gates shut and the sequence is idle.
- `busy` out 1: a stop or start sequence is in progress.
- `timeout_flag` out 1: sticky; set when any channel wait times out.
- `timeout_channel` out C_IDX_WIDTH: index of the first channel that timed out since the last clear.
- `timeout_clr` in 1: one-cycle pulse that clears `timeout_flag` and `timeout_channel`.

## Operation

- FSM states are RUNNING, STOPPING, STOPPED and STARTING. There is an index register `idx` and a wait counter `cnt`.
- **Reset values:**
  - state = RUNNING, `shutdown_req` = 0, `running` = 1, `stopped` = 0, `busy` = 0.
  - `timeout_flag` = 0, `timeout_channel` = 0, `idx` = 0, `cnt` = 0.
- **RUNNING:**
  - When `stop_req` = 1, go to STOPPING with `idx` = 0 and `cnt` = 0.
  - Set `shutdown_req[0]` = 1 on the same edge.
- **STOPPING:** wait for `shutdown_ack[idx]` = 1 or a timeout, then:
  - If `idx` = C_NUM_CHANNELS-1, go to STOPPED.
  - Otherwise, increment `idx`, set `shutdown_req[idx+1]` = 1 and reset `cnt` to 0, all on the same edge.
  - Bits already set stay set.
- **STOPPED:**
  - When `stop_req` = 0, go to STARTING with `idx` = C_NUM_CHANNELS-1 and `cnt` = 0.
  - Clear `shutdown_req[C_NUM_CHANNELS-1]` on the same edge.
- **STARTING:** wait for `shutdown_ack[idx]` = 0 or a timeout, then:
  - If `idx` = 0, go to RUNNING.
  - Otherwise, decrement `idx`, clear `shutdown_req[idx-1]` and reset `cnt` to 0.
- **Status outputs:**
  - `running` = (state == RUNNING), `stopped` = (state == STOPPED), `busy` = STOPPING or STARTING.
  - All three are registered, so they change on the same edge as the state.
- **Sequences are atomic.** A change of `stop_req` during STOPPING or STARTING is ignored. The level is re-evaluated in STOPPED or RUNNING, and the opposite sequence starts on the edge after the state is reached.
- **Timeout:**
  - `cnt` increments each cycle that the awaited ack is not matched.
  - With C_TIMEOUT_CYCLES = T > 0, the wait fires when `cnt` = T-1 and the ack is still unmatched, so the wait lasts exactly T cycles after the request change.
  - On firing, the FSM advances exactly as if the ack had arrived.
  - If `timeout_flag` was 0, set it and latch `timeout_channel` = `idx`. If it was already 1, `timeout_channel` is unchanged.
  - An ack matched on the firing edge takes priority, and no timeout is recorded.
  - `cnt` saturates and needs only $clog2(T+1) bits.
- **Clear vs. set:** `timeout_clr` clears the flag and the channel. A timeout on the same edge wins: the flag is set and the current `idx` is latched.
- **Ack bits outside the current wait** (other channels, or any ack while idle) are ignored.
- **Asynchronous reset mid-sequence** returns every output to its reset value immediately, so all gates are released at once.

## Timing

- Request latency:
  - `stop_req` rising at edge E gives `shutdown_req[0]` = 1 and `busy` = 1 after E+1.
  - An ack first sampled high at edge A gives the next request bit changing after A+1.
- With gates whose ack follows the request by 2 cycles:
  - Each channel costs 3 cycles.
  - A full stop takes 3·C_NUM_CHANNELS cycles from the first request edge to `stopped` = 1.
- Status change: `stopped` or `running` asserts on the edge that consumes the final ack, one cycle after that ack is visible.
- Throughput: one channel transition per wait completion; no pipelining across channels.

## Test plan

- **Nominal stop.** N=3, T=8, gate models with 2-cycle ack; raise `stop_req`.
  - `shutdown_req` steps 001→011→111, 3 cycles apart.
  - `stopped` = 1 nine cycles after the first request edge; `timeout_flag` = 0.
- **Nominal start.** From STOPPED, drop `stop_req`.
  - `shutdown_req` steps 111→011→001→000 in reverse order.
  - `running` = 1 at the end; `busy` = 1 only in between.
- **Stuck gate.** Channel 1 ack tied low, T=8.
  - `shutdown_req[2]` rises exactly 8 cycles after `shutdown_req[1]`.
  - `timeout_flag` = 1, `timeout_channel` = 1, and the sequence still reaches STOPPED.
- **Flag handling.**
  - A second timeout on channel 2 leaves `timeout_channel` = 1.
  - `timeout_clr` pulsed on the same edge as a new timeout leaves the flag = 1 with the new channel latched.
  - `timeout_clr` alone clears both to 0.
- **Request toggle mid-sequence.** Raise `stop_req`, drop it 2 cycles later.
  - The stop completes to 111 and STOPPED.
  - STARTING begins on the next edge and ends at RUNNING with `shutdown_req` = 000.
- **Reset mid-sequence.** Assert `rst_n` = 0 asynchronously in STOPPING with `idx` = 1.
  - `shutdown_req` = 000, `running` = 1 and `busy` = 0 immediately, without waiting for a clock edge.
  - The flag is cleared, and operation resumes normally after release.
